alu32_serial: RTL and testbench
===============================

ALU32_SERIAL -- requirements
Module: alu32_serial

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk and rst_n. Reset asserts immediately when rst_n goes low and releases synchronously to clk.
REQ-002 Port list, in order:
  clk  in  1  rising-edge clock.
  rst_n  in  1  asynchronous active-low reset.
  in_valid  in  1  request present.
  in_ready  out  1  block can accept a request.
  a  in  32  operand A.
  b  in  32  operand B.
  op  in  3  operation select.
  out_valid  out  1  result present.
  out_ready  in  1  consumer accepts the result.
  result  out  32  operation result.
  zero  out  1  result equals 0.
  carry  out  1  final carry out (ADD/SUB only).
  overflow  out  1  signed overflow (ADD/SUB only).

Function
REQ-003 Opcodes SHALL be decoded as follows:
  000 AND
  001 OR
  010 ADD
  011 XOR
  100 NOR
  101 SUB (a-b)
  110 SLT signed
  111 SLTU unsigned
REQ-004 The FSM SHALL have three states: IDLE, RUN and DONE. The reset state is IDLE.
REQ-005 in_ready SHALL be 1 only in IDLE. out_valid SHALL be 1 only in DONE.
REQ-006 A request is accepted on a rising edge where in_valid and in_ready are both 1. On that edge:
  - a, b and op are captured into internal registers;
  - the bit counter is cleared to 0;
  - the carry register is set to 1 for SUB, SLT and SLTU, and to 0 otherwise;
  - the state moves to RUN.
REQ-007 Changes on a, b or op after acceptance SHALL have no effect on the operation in progress.
REQ-008 Each edge in RUN SHALL process exactly one bit i = counter value, LSB first:
  - the operand B bit is inverted for SUB, SLT and SLTU;
  - the sum bit and next carry are computed by a 1-bit full adder;
  - the logic-op bit is computed directly;
  - the resulting bit is stored at position i;
  - the counter increments by 1.
REQ-009 On the edge that processes bit 31, the counter SHALL wrap to 0 and the state SHALL move to DONE. out_valid is therefore first visible 32 edges after the accept edge.
REQ-010 For SLT, the result SHALL be {31'b0, N^V}, where N is the bit-31 difference bit and V is the subtraction overflow. For SLTU, the result SHALL be {31'b0, ~carry_final}.
REQ-011 carry SHALL equal the final carry out for ADD and SUB, and 0 for all other ops. For SUB, carry=1 means no borrow.
REQ-012 overflow SHALL equal (carry into bit 31) XOR (carry out of bit 31) for ADD and SUB, and 0 otherwise.
REQ-013 zero SHALL equal (result == 0) for every op.
REQ-014 result, zero, carry and overflow SHALL be registered and SHALL stay stable for the whole DONE state.
REQ-015 In DONE, out_valid SHALL stay 1 until out_ready is 1. The state moves to IDLE on the edge where out_valid and out_ready are both 1.
REQ-016 No request SHALL be accepted in RUN or DONE; in_valid is ignored there.
REQ-017 Following an output handshake, in_ready SHALL become 1 in the very next cycle. The minimum issue interval is therefore 34 cycles.
REQ-018 Holding out_ready high before DONE SHALL NOT shorten the latency.

Reset
REQ-019 While rst_n=0, the block SHALL hold these values:
  - state IDLE, counter 0, carry register 0;
  - in_ready 1, out_valid 0;
  - result 0, zero 0, carry 0, overflow 0.
REQ-020 Reset asserted in RUN or DONE SHALL abort the operation and discard the partial result. After release, the block SHALL accept a new request on the first edge with in_valid=1.

Verification
REQ-021 ADD: a=0x00000003, b=0x00000001, op=010. Required: out_valid rises 32 edges after accept; result=0x00000004, zero=0, carry=0, overflow=0.
REQ-022 SUB: a=0x00000000, b=0x00000001, op=101. Required: result=0xFFFFFFFF, carry=0, overflow=0, zero=0. Repeat with a=b=0x12345678. Required: result=0, zero=1, carry=1.
REQ-023 ADD overflow: a=0x7FFFFFFF, b=0x00000001, op=010. Required: result=0x80000000, overflow=1, carry=0. Also a=b=0xFFFFFFFF. Required: result=0xFFFFFFFE, carry=1, overflow=0.
REQ-024 Compare: a=0x95000000, b=0xFCA00001.
  - SLT (110) -> result 0x00000001.
  - SLTU (111) -> result 0x00000001.
  - Swapped operands -> result 0x00000000 for both ops.
  Logic ops on the same operands:
  - AND (000) -> 0x94000000.
  - NOR (100) -> 0x025FFFFE.
REQ-025 Backpressure and isolation:
  - Hold out_ready=0 for 5 cycles in DONE. Required: result and flags stable, in_ready=0.
  - Change a, b, op and pulse in_valid during RUN. Required: no effect on the result.
  - After the handshake, in_ready=1 on the next cycle.
REQ-026 Reset mid-run: pull rst_n low 10 edges into RUN. Required: out_valid=0, in_ready=1, all outputs 0. Next request ADD 3+1 returns 0x00000004.

Source files
------------

// File: rtl/alu32_serial.sv
// Bit-serial 32-bit ALU (AND/OR/ADD/XOR/NOR/SUB/SLT/SLTU), one result bit per clock, LSB first.
// Latency: out_valid rises 32 edges after the accept edge; minimum issue interval is 34 cycles.
// Backpressure: result held stable in DONE until out_ready; no request is accepted outside IDLE.
module alu32_serial (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        zero,
    output logic        carry,
    output logic        overflow
);
    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_SLT  = 3'b110;
    localparam logic [2:0] OP_SLTU = 3'b111;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [31:0] a_q, b_q, acc;
    logic [2:0]  op_q;
    logic [4:0]  cnt;
    logic        cy;

    logic        bit_a, bit_b, bb, sum, cout, bit_r, arith;
    logic [31:0] word, fin_res;
    logic        fin_c, fin_v;

    // Subtract-style ops add ~b with an initial carry of 1.
    function automatic logic is_sub(input logic [2:0] o);
        return (o == OP_SUB) || (o == OP_SLT) || (o == OP_SLTU);
    endfunction

    always_comb begin
        bit_a = a_q[cnt];
        bit_b = b_q[cnt];
        bb    = bit_b ^ is_sub(op_q);
        sum   = bit_a ^ bb ^ cy;
        cout  = (bit_a & bb) | (cy & (bit_a ^ bb));
        case (op_q)
            OP_AND:  bit_r = bit_a & bit_b;
            OP_OR:   bit_r = bit_a | bit_b;
            OP_XOR:  bit_r = bit_a ^ bit_b;
            OP_NOR:  bit_r = ~(bit_a | bit_b);
            default: bit_r = sum;
        endcase
        word      = acc;
        word[cnt] = bit_r;
        // Only meaningful on the bit-31 edge: cy is then the carry into bit 31.
        fin_res = word;
        if (op_q == OP_SLT)  fin_res = {31'b0, sum ^ (cy ^ cout)};
        if (op_q == OP_SLTU) fin_res = {31'b0, ~cout};
        arith = (op_q == OP_ADD) || (op_q == OP_SUB);
        fin_c = arith & cout;
        fin_v = arith & (cy ^ cout);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            acc       <= '0;
            cnt       <= '0;
            cy        <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        op_q     <= op;
                        acc      <= '0;
                        cnt      <= '0;
                        cy       <= is_sub(op);
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc <= word;
                    cy  <= cout;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        result    <= fin_res;
                        zero      <= (fin_res == 32'd0);
                        carry     <= fin_c;
                        overflow  <= fin_v;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu32_serial.sv
// Directed bench for alu32_serial: arithmetic model plus cycle-level handshake model, with literal pins.
module tb_alu32_serial;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready;
    logic        zero, carry, overflow;
    logic [31:0] a, b, result;
    logic [2:0]  op;

    int checks = 0;
    int failures = 0;

    bit          m_busy = 1'b0;
    int          m_wait = 0;
    logic [31:0] m_res = '0;
    logic        m_c = 1'b0, m_v = 1'b0;

    bit          lit_vld = 1'b0;
    logic [31:0] lit_res = '0;
    logic        lit_z = 1'b0, lit_c = 1'b0, lit_v = 1'b0;

    alu32_serial dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .carry(carry), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic c, output logic v);
        logic [32:0] s;
        c = 1'b0;
        v = 1'b0;
        case (o)
            3'b000: r = x & y;
            3'b001: r = x | y;
            3'b011: r = x ^ y;
            3'b100: r = ~(x | y);
            3'b010: begin
                s = {1'b0, x} + {1'b0, y};
                r = s[31:0];
                c = s[32];
                v = (x[31] == y[31]) && (r[31] != x[31]);
            end
            3'b101: begin
                s = {1'b0, x} + {1'b0, ~y} + 33'd1;
                r = s[31:0];
                c = s[32];
                v = (x[31] != y[31]) && (r[31] != x[31]);
            end
            3'b110:  r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            default: r = (x < y) ? 32'd1 : 32'd0;
        endcase
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    // Compare process: checks outputs every cycle, then advances the model past the coming edge.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            chk1("rst_in_ready", in_ready, 1'b1);
            chk1("rst_out_valid", out_valid, 1'b0);
            chk32("rst_result", result, 32'd0);
            chk1("rst_zero", zero, 1'b0);
            chk1("rst_carry", carry, 1'b0);
            chk1("rst_overflow", overflow, 1'b0);
            m_busy = 1'b0;
            m_wait = 0;
        end else begin
            chk1("in_ready", in_ready, !m_busy);
            chk1("out_valid", out_valid, m_busy && (m_wait == 0));
            if (m_busy && (m_wait == 0)) begin
                chk32("result", result, m_res);
                chk1("zero", zero, m_res == 32'd0);
                chk1("carry", carry, m_c);
                chk1("overflow", overflow, m_v);
                if (lit_vld) begin
                    chk32("lit_result", result, lit_res);
                    chk1("lit_zero", zero, lit_z);
                    chk1("lit_carry", carry, lit_c);
                    chk1("lit_overflow", overflow, lit_v);
                end
            end
            if (!m_busy) begin
                if (in_valid) begin
                    model(op, a, b, m_res, m_c, m_v);
                    m_busy = 1'b1;
                    m_wait = 32;
                end
            end else if (m_wait > 0) begin
                m_wait--;
            end else if (out_ready) begin
                m_busy = 1'b0;
            end
        end
    end

    // Called at posedge+1 with the block idle; returns at posedge+1 right after the output handshake.
    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] lr, input logic lz, input logic lc, input logic lv,
                         input int hold, input bit glitch, input bit early);
        lit_vld = 1'b1;
        lit_res = lr;
        lit_z = lz;
        lit_c = lc;
        lit_v = lv;
        op = o;
        a = x;
        b = y;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = early;
        for (int i = 0; i < 32; i++) begin
            if (glitch) begin
                a = $urandom;
                b = $urandom;
                op = 3'($urandom_range(7));
                in_valid = i[0];
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (hold) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        lit_vld = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        op = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        do_op(3'b010, 32'h00000003, 32'h00000001, 32'h00000004, 0, 0, 0, 0, 0, 0);
        do_op(3'b101, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0);
        do_op(3'b101, 32'h12345678, 32'h12345678, 32'h00000000, 1, 1, 0, 5, 0, 0);
        do_op(3'b010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 0, 1, 0, 1, 0);
        do_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 1, 0, 2, 0, 1);
        do_op(3'b110, 32'h95000000, 32'hFCA00001, 32'h00000001, 0, 0, 0, 0, 0, 0);
        do_op(3'b111, 32'h95000000, 32'hFCA00001, 32'h00000001, 0, 0, 0, 0, 0, 0);
        do_op(3'b110, 32'hFCA00001, 32'h95000000, 32'h00000000, 1, 0, 0, 0, 0, 0);
        do_op(3'b111, 32'hFCA00001, 32'h95000000, 32'h00000000, 1, 0, 0, 0, 0, 0);
        do_op(3'b000, 32'h95000000, 32'hFCA00001, 32'h94000000, 0, 0, 0, 0, 0, 0);
        do_op(3'b100, 32'h95000000, 32'hFCA00001, 32'h025FFFFE, 0, 0, 0, 0, 0, 0);
        do_op(3'b001, 32'h95000000, 32'hFCA00001, 32'hFDA00001, 0, 0, 0, 0, 0, 0);
        do_op(3'b011, 32'h95000000, 32'hFCA00001, 32'h69A00001, 0, 0, 0, 1, 1, 0);

        // Abort a subtraction 10 edges into RUN.
        op = 3'b101;
        a = 32'h00000000;
        b = 32'h00000001;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        do_op(3'b010, 32'h00000003, 32'h00000001, 32'h00000004, 0, 0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
